// File: rtl/core101_pkg.sv
// core101_pkg: encodings shared by the Core101 memory arbiter and its helpers.
package core101_pkg;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_IFU  = 2'd1;
   localparam logic [1:0] ARB_LSU  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ARB_IDLE,
      ST_IFU  = ARB_IFU,
      ST_LSU  = ARB_LSU
   } arb_state_e;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } owner_e;

   // Which requester owns the memory port in a given access state.
   function automatic owner_e state_owner(arb_state_e st);
      return (st == ST_LSU) ? OWNER_LSU : OWNER_IFU;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts cycles spent in an access state and flags the
// cycle that is the LIMIT-th one without a memory completion.
module arb_timeout_counter #(
   parameter int LIMIT = 16,
   parameter int CNT_W = 5
) (
   input  logic clock_in,
   input  logic reset_in,
   input  logic clear_in,
   input  logic enable_in,
   output logic expired_out
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count access cycles already elapsed; holds at LIMIT-1 so it never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_in) begin
         cnt_d = '0;
      end else if (enable_in && (cnt_q != CNT_W'(LIMIT - 1))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_out = enable_in && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between the IFU and the LSU, with
// an access timeout and bounded IFU starvation. All outputs are registered.
module mem_arbiter
   import core101_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int STARVE_LIMIT   = 4,
   parameter int CNT_W          = 5
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        halt_in,
   input  logic        ifu_req_in,
   input  logic [31:0] ifu_addr_in,
   output logic        ifu_gnt_out,
   output logic [31:0] ifu_data_out,
   output logic        ifu_valid_out,
   output logic        ifu_err_out,
   input  logic        lsu_req_in,
   input  logic        lsu_we_in,
   input  logic [31:0] lsu_addr_in,
   input  logic [31:0] lsu_wdata_in,
   output logic        lsu_gnt_out,
   output logic [31:0] lsu_rdata_out,
   output logic        lsu_valid_out,
   output logic        lsu_err_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   input  logic [31:0] mem_rdata_in,
   input  logic        mem_valid_in
);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [31:0]      ifu_data_q, ifu_data_d;
   logic [31:0]      lsu_data_q, lsu_data_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             ifu_gnt_q, ifu_gnt_d;
   logic             ifu_valid_q, ifu_valid_d;
   logic             ifu_err_q, ifu_err_d;
   logic             lsu_gnt_q, lsu_gnt_d;
   logic             lsu_valid_q, lsu_valid_d;
   logic             lsu_err_q, lsu_err_d;
   logic             ifu_eligible;
   logic             ifu_starved;
   logic             in_access;
   logic             timeout_expired;

   assign ifu_eligible = ifu_req_in && !halt_in;
   assign ifu_starved  = (starve_q == CNT_W'(STARVE_LIMIT));
   assign in_access    = (state_q != ST_IDLE);

   arb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clock_in    (clock_in),
      .reset_in    (reset_in),
      .clear_in    (!in_access),
      .enable_in   (in_access),
      .expired_out (timeout_expired)
   );

   // Next-state logic: arbitrate in IDLE, complete or time out in an access.
   // The LSU only wins while the starvation count is below the limit, so the
   // increment below saturates at STARVE_LIMIT without an explicit clamp.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      ifu_data_d  = ifu_data_q;
      lsu_data_d  = lsu_data_q;
      ifu_gnt_d   = 1'b0;
      ifu_valid_d = 1'b0;
      ifu_err_d   = 1'b0;
      lsu_gnt_d   = 1'b0;
      lsu_valid_d = 1'b0;
      lsu_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lsu_req_in && !(ifu_eligible && ifu_starved)) begin
               state_d     = ST_LSU;
               lsu_gnt_d   = 1'b1;
               mem_addr_d  = lsu_addr_in;
               mem_wdata_d = lsu_wdata_in;
               mem_write_d = lsu_we_in;
               mem_read_d  = !lsu_we_in;
               if (ifu_eligible) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (ifu_eligible) begin
               state_d     = ST_IFU;
               ifu_gnt_d   = 1'b1;
               mem_addr_d  = ifu_addr_in;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               starve_d    = '0;
            end
         end
         ST_IFU, ST_LSU: begin
            if (mem_valid_in || timeout_expired) begin
               state_d     = ST_IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_owner(state_q) == OWNER_IFU) begin
                  ifu_valid_d = 1'b1;
                  ifu_err_d   = !mem_valid_in;
                  ifu_data_d  = mem_valid_in ? mem_rdata_in : 32'h0;
               end else begin
                  lsu_valid_d = 1'b1;
                  lsu_err_d   = !mem_valid_in;
                  if (!mem_valid_in) begin
                     lsu_data_d = 32'h0;
                  end else if (!mem_write_q) begin
                     lsu_data_d = mem_rdata_in;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronously cleared by reset.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         ifu_data_q  <= '0;
         lsu_data_q  <= '0;
         ifu_gnt_q   <= 1'b0;
         ifu_valid_q <= 1'b0;
         ifu_err_q   <= 1'b0;
         lsu_gnt_q   <= 1'b0;
         lsu_valid_q <= 1'b0;
         lsu_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         ifu_data_q  <= ifu_data_d;
         lsu_data_q  <= lsu_data_d;
         ifu_gnt_q   <= ifu_gnt_d;
         ifu_valid_q <= ifu_valid_d;
         ifu_err_q   <= ifu_err_d;
         lsu_gnt_q   <= lsu_gnt_d;
         lsu_valid_q <= lsu_valid_d;
         lsu_err_q   <= lsu_err_d;
      end
   end

   assign ifu_gnt_out   = ifu_gnt_q;
   assign ifu_data_out  = ifu_data_q;
   assign ifu_valid_out = ifu_valid_q;
   assign ifu_err_out   = ifu_err_q;
   assign lsu_gnt_out   = lsu_gnt_q;
   assign lsu_rdata_out = lsu_data_q;
   assign lsu_valid_out = lsu_valid_q;
   assign lsu_err_out   = lsu_err_q;
   assign mem_addr_out  = mem_addr_q;
   assign mem_wdata_out = mem_wdata_q;
   assign mem_read_out  = mem_read_q;
   assign mem_write_out = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int TIMEOUT_CYCLES = 16;
   localparam int STARVE_LIMIT   = 4;
   localparam int CNT_W          = 5;
   localparam int OWN_NONE       = 0;
   localparam int OWN_IFU        = 1;
   localparam int OWN_LSU        = 2;

   logic        clock_in;
   logic        reset_in;
   logic        halt_in;
   logic        ifu_req_in;
   logic [31:0] ifu_addr_in;
   logic        ifu_gnt_out;
   logic [31:0] ifu_data_out;
   logic        ifu_valid_out;
   logic        ifu_err_out;
   logic        lsu_req_in;
   logic        lsu_we_in;
   logic [31:0] lsu_addr_in;
   logic [31:0] lsu_wdata_in;
   logic        lsu_gnt_out;
   logic [31:0] lsu_rdata_out;
   logic        lsu_valid_out;
   logic        lsu_err_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_wdata_out;
   logic        mem_read_out;
   logic        mem_write_out;
   logic [31:0] mem_rdata_in;
   logic        mem_valid_in;

   int checks = 0;
   int errors = 0;
   bit checkEnable = 1'b0;
   int validPct = 50;

   // Model state: who owns the port, how long the access has run, IFU losses.
   int mOwner = OWN_NONE;
   int mAge = 0;
   int mLosses = 0;
   bit mWrite = 1'b0;
   logic        expIfuGnt, expIfuValid, expIfuErr;
   logic        expLsuGnt, expLsuValid, expLsuErr;
   logic        expRead, expWrite;
   logic [31:0] expIfuData, expLsuData, expAddr, expWdata;

   mem_arbiter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .STARVE_LIMIT   (STARVE_LIMIT),
      .CNT_W          (CNT_W)
   ) dut (
      .clock_in      (clock_in),
      .reset_in      (reset_in),
      .halt_in       (halt_in),
      .ifu_req_in    (ifu_req_in),
      .ifu_addr_in   (ifu_addr_in),
      .ifu_gnt_out   (ifu_gnt_out),
      .ifu_data_out  (ifu_data_out),
      .ifu_valid_out (ifu_valid_out),
      .ifu_err_out   (ifu_err_out),
      .lsu_req_in    (lsu_req_in),
      .lsu_we_in     (lsu_we_in),
      .lsu_addr_in   (lsu_addr_in),
      .lsu_wdata_in  (lsu_wdata_in),
      .lsu_gnt_out   (lsu_gnt_out),
      .lsu_rdata_out (lsu_rdata_out),
      .lsu_valid_out (lsu_valid_out),
      .lsu_err_out   (lsu_err_out),
      .mem_addr_out  (mem_addr_out),
      .mem_wdata_out (mem_wdata_out),
      .mem_read_out  (mem_read_out),
      .mem_write_out (mem_write_out),
      .mem_rdata_in  (mem_rdata_in),
      .mem_valid_in  (mem_valid_in)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   // One comparison: counts it, and reports it when the values differ.
   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every DUT output with the model's prediction for this cycle.
   task automatic checkOutput();
      checkValue("ifu_gnt", 32'(ifu_gnt_out), 32'(expIfuGnt));
      checkValue("ifu_valid", 32'(ifu_valid_out), 32'(expIfuValid));
      checkValue("ifu_err", 32'(ifu_err_out), 32'(expIfuErr));
      checkValue("ifu_data", ifu_data_out, expIfuData);
      checkValue("lsu_gnt", 32'(lsu_gnt_out), 32'(expLsuGnt));
      checkValue("lsu_valid", 32'(lsu_valid_out), 32'(expLsuValid));
      checkValue("lsu_err", 32'(lsu_err_out), 32'(expLsuErr));
      checkValue("lsu_rdata", lsu_rdata_out, expLsuData);
      checkValue("mem_addr", mem_addr_out, expAddr);
      checkValue("mem_wdata", mem_wdata_out, expWdata);
      checkValue("mem_read", 32'(mem_read_out), 32'(expRead));
      checkValue("mem_write", 32'(mem_write_out), 32'(expWrite));
      checkValue("strobe_exclusive", 32'(mem_read_out && mem_write_out), 32'h0);
   endtask

   // Transaction-level model: decides what each register must hold after
   // this edge from the arbitration, completion and timeout rules.
   always @(posedge clock_in) begin
      bit ifuOk;
      int winner;
      bit ok;
      if (reset_in) begin
         mOwner = OWN_NONE; mAge = 0; mLosses = 0; mWrite = 1'b0;
         expIfuGnt = 0; expIfuValid = 0; expIfuErr = 0;
         expLsuGnt = 0; expLsuValid = 0; expLsuErr = 0;
         expRead = 0; expWrite = 0;
         expIfuData = 0; expLsuData = 0; expAddr = 0; expWdata = 0;
      end else begin
         expIfuGnt = 0; expIfuValid = 0; expIfuErr = 0;
         expLsuGnt = 0; expLsuValid = 0; expLsuErr = 0;
         if (mOwner == OWN_NONE) begin
            ifuOk = ifu_req_in && !halt_in;
            winner = OWN_NONE;
            if (lsu_req_in && ifuOk) winner = (mLosses >= STARVE_LIMIT) ? OWN_IFU : OWN_LSU;
            else if (lsu_req_in) winner = OWN_LSU;
            else if (ifuOk) winner = OWN_IFU;
            if (winner == OWN_LSU) begin
               if (ifuOk && mLosses < STARVE_LIMIT) mLosses++;
               expLsuGnt = 1; expAddr = lsu_addr_in; expWdata = lsu_wdata_in;
               mWrite = lsu_we_in; expWrite = lsu_we_in; expRead = !lsu_we_in;
            end else if (winner == OWN_IFU) begin
               mLosses = 0;
               expIfuGnt = 1; expAddr = ifu_addr_in;
               mWrite = 1'b0; expWrite = 0; expRead = 1;
            end
            mOwner = winner;
            mAge = 0;
         end else begin
            mAge++;
            if (mem_valid_in || mAge == TIMEOUT_CYCLES) begin
               ok = mem_valid_in;
               expRead = 0; expWrite = 0;
               if (mOwner == OWN_IFU) begin
                  expIfuValid = 1; expIfuErr = !ok;
                  expIfuData = ok ? mem_rdata_in : 32'h0;
               end else begin
                  expLsuValid = 1; expLsuErr = !ok;
                  if (!ok) expLsuData = 32'h0;
                  else if (!mWrite) expLsuData = mem_rdata_in;
               end
               mOwner = OWN_NONE;
            end
         end
      end
   end

   // Single compare process, sampling on the falling edge.
   always @(negedge clock_in) begin
      if (checkEnable) checkOutput();
   end

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   // Random inputs for one cycle of the randomized phase.
   task automatic applyStimulus();
      reset_in     = ($urandom_range(0, 399) == 0);
      halt_in      = ($urandom_range(0, 99) < 15);
      ifu_req_in   = ($urandom_range(0, 99) < 60);
      ifu_addr_in  = $urandom;
      lsu_req_in   = ($urandom_range(0, 99) < 50);
      lsu_we_in    = $urandom_range(0, 1);
      lsu_addr_in  = $urandom;
      lsu_wdata_in = $urandom;
      mem_rdata_in = $urandom;
      mem_valid_in = ($urandom_range(0, 99) < validPct);
   endtask

   initial begin
      int expOrder[10];
      int grants[$];
      int highCnt;
      int otherCnt;
      bit done;
      int pcts[4];
      expOrder = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
      pcts = '{0, 20, 60, 100};

      reset_in = 1; halt_in = 0; ifu_req_in = 0; ifu_addr_in = 0;
      lsu_req_in = 0; lsu_we_in = 0; lsu_addr_in = 0; lsu_wdata_in = 0;
      mem_rdata_in = 0; mem_valid_in = 0;
      repeat (3) tick();
      checkEnable = 1'b1;
      checkValue("reset_mem_read", 32'(mem_read_out), 32'h0);
      checkValue("reset_ifu_data", ifu_data_out, 32'h0);
      reset_in = 0;
      tick();

      // IFU read, zero-wait memory.
      ifu_req_in = 1; ifu_addr_in = 32'h10;
      tick();
      checkValue("ifu0_gnt", 32'(ifu_gnt_out), 32'h1);
      checkValue("ifu0_read", 32'(mem_read_out), 32'h1);
      checkValue("ifu0_addr", mem_addr_out, 32'h10);
      ifu_req_in = 0; mem_valid_in = 1; mem_rdata_in = 32'hDEADBEEF;
      tick();
      checkValue("ifu0_valid", 32'(ifu_valid_out), 32'h1);
      checkValue("ifu0_data", ifu_data_out, 32'hDEADBEEF);
      checkValue("ifu0_read_drop", 32'(mem_read_out), 32'h0);
      mem_valid_in = 0;
      tick();

      // LSU write, memory completes after three wait cycles.
      lsu_req_in = 1; lsu_we_in = 1; lsu_addr_in = 32'h40; lsu_wdata_in = 32'h12345678;
      mem_rdata_in = 32'hBAD0BAD0;
      tick();
      checkValue("lsuw_gnt", 32'(lsu_gnt_out), 32'h1);
      checkValue("lsuw_wdata", mem_wdata_out, 32'h12345678);
      lsu_req_in = 0;
      highCnt = 0; otherCnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem_write_out) highCnt++;
         if (mem_read_out) otherCnt++;
         mem_valid_in = (i == 3);
         tick();
      end
      checkValue("lsuw_write_cycles", 32'(highCnt), 32'd4);
      checkValue("lsuw_read_cycles", 32'(otherCnt), 32'd0);
      checkValue("lsuw_valid", 32'(lsu_valid_out), 32'h1);
      checkValue("lsuw_rdata_kept", lsu_rdata_out, 32'h0);
      mem_valid_in = 0; lsu_we_in = 0;
      tick();

      // Both requesting continuously: starvation bound on the IFU.
      ifu_req_in = 1; ifu_addr_in = 32'h100; lsu_req_in = 1; lsu_addr_in = 32'h200;
      mem_valid_in = 1; mem_rdata_in = 32'hA5A50001;
      for (int i = 0; i < 60 && grants.size() < 10; i++) begin
         tick();
         if (ifu_gnt_out) grants.push_back(1);
         if (lsu_gnt_out) grants.push_back(2);
      end
      ifu_req_in = 0; lsu_req_in = 0;
      tick();
      mem_valid_in = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
         checkValue($sformatf("starve_order%0d", i), 32'((i < grants.size()) ? grants[i] : 0), 32'(expOrder[i]));
      end

      // LSU read that times out.
      lsu_req_in = 1; lsu_we_in = 0; lsu_addr_in = 32'h80;
      tick();
      checkValue("to_gnt", 32'(lsu_gnt_out), 32'h1);
      lsu_req_in = 0;
      highCnt = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (mem_read_out) highCnt++;
         tick();
         if (lsu_valid_out) done = 1;
      end
      checkValue("to_strobe_cycles", 32'(highCnt), 32'd16);
      checkValue("to_valid", 32'(lsu_valid_out), 32'h1);
      checkValue("to_err", 32'(lsu_err_out), 32'h1);
      checkValue("to_rdata", lsu_rdata_out, 32'h0);
      ifu_req_in = 1; ifu_addr_in = 32'h300;
      tick();
      checkValue("to_next_gnt", 32'(ifu_gnt_out), 32'h1);
      ifu_req_in = 0; mem_valid_in = 1;
      tick();
      checkValue("to_next_err", 32'(ifu_err_out), 32'h0);
      mem_valid_in = 0;
      tick();

      // Halt blocks IFU grants but not an in-flight fetch.
      halt_in = 1; ifu_req_in = 1; ifu_addr_in = 32'h400;
      otherCnt = 0;
      repeat (4) begin
         tick();
         if (ifu_gnt_out) otherCnt++;
      end
      checkValue("halt_no_gnt", 32'(otherCnt), 32'd0);
      halt_in = 0;
      tick();
      checkValue("halt_release_gnt", 32'(ifu_gnt_out), 32'h1);
      halt_in = 1;
      tick();
      tick();
      mem_valid_in = 1; mem_rdata_in = 32'hCAFEF00D; ifu_req_in = 0;
      tick();
      checkValue("halt_fetch_valid", 32'(ifu_valid_out), 32'h1);
      checkValue("halt_fetch_data", ifu_data_out, 32'hCAFEF00D);
      mem_valid_in = 0; halt_in = 0;
      tick();

      // Reset in the middle of an LSU access, then a late completion.
      lsu_req_in = 1; lsu_we_in = 0; lsu_addr_in = 32'h500;
      tick();
      checkValue("rst_gnt", 32'(lsu_gnt_out), 32'h1);
      lsu_req_in = 0;
      tick();
      tick();
      reset_in = 1;
      tick();
      checkValue("rst_read", 32'(mem_read_out), 32'h0);
      checkValue("rst_addr", mem_addr_out, 32'h0);
      checkValue("rst_ifu_data", ifu_data_out, 32'h0);
      reset_in = 0; mem_valid_in = 1;
      otherCnt = 0;
      repeat (3) begin
         tick();
         if (lsu_valid_out || ifu_valid_out || mem_read_out) otherCnt++;
      end
      checkValue("rst_late_valid", 32'(otherCnt), 32'd0);
      mem_valid_in = 0;
      tick();

      // Randomized traffic with varying memory responsiveness.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) validPct = pcts[$urandom_range(0, 3)];
         applyStimulus();
         tick();
      end

      reset_in = 0; ifu_req_in = 0; lsu_req_in = 0; mem_valid_in = 1;
      repeat (3) tick();
      checkEnable = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between two requesters: the instruction fetch unit (IFU) and the load/store unit (LSU).
- Owns mem_read_out, mem_write_out and the address and data toward memory. Completes each access on the mem_valid_in handshake.
- Enforces a timeout on each access and bounds IFU starvation.
- Sits between ifu0/lsu and main memory in Core101_top.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in an access state without mem_valid_in before the access is aborted with an error.
- STARVE_LIMIT, 4: consecutive IFU losses to the LSU after which the IFU wins the next contended arbitration.
- CNT_W, 5: width of the timeout and starvation counters. Must satisfy 2^CNT_W > max(TIMEOUT_CYCLES, STARVE_LIMIT).

Ports:
- clock_in  in  1  core clock
- reset_in  in  1  synchronous, active-high reset
- halt_in  in  1  while high, IFU requests are not granted; the LSU is unaffected
- ifu_req_in  in  1  IFU read request
- ifu_addr_in  in  32  IFU read address
- ifu_gnt_out  out  1  one-cycle pulse: IFU request accepted
- ifu_data_out  out  32  IFU read data, valid when ifu_valid_out is high
- ifu_valid_out  out  1  one-cycle pulse: IFU access complete
- ifu_err_out  out  1  one-cycle pulse with ifu_valid_out: IFU access timed out
- lsu_req_in  in  1  LSU request
- lsu_we_in  in  1  1 = write, 0 = read
- lsu_addr_in  in  32  LSU address
- lsu_wdata_in  in  32  LSU write data
- lsu_gnt_out  out  1  one-cycle pulse: LSU request accepted
- lsu_rdata_out  out  32  LSU read data
- lsu_valid_out  out  1  one-cycle pulse: LSU access complete
- lsu_err_out  out  1  one-cycle pulse with lsu_valid_out: LSU access timed out
- mem_addr_out  out  32  latched access address
- mem_wdata_out  out  32  latched write data
- mem_read_out  out  1  read strobe, held high for the whole read access
- mem_write_out  out  1  write strobe, held high for the whole write access
- mem_rdata_in  in  32  memory read data
- mem_valid_in  in  1  memory completion

Behaviour:
- Reset (synchronous, active-high, clock_in):
  - State = IDLE.
  - All outputs 0, including data outputs.
  - Timeout counter = 0, starvation counter = 0.
  - Reset mid-access abandons the access with no valid or err pulse. A later mem_valid_in in IDLE is ignored.
- States: IDLE, IFU_ACC, LSU_ACC.
- IDLE arbitration, evaluated every cycle:
  - The IFU request is eligible only if ifu_req_in && !halt_in.
  - LSU only: grant LSU.
  - IFU only: grant IFU.
  - Both: LSU wins unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - An IFU loss to the LSU increments starve_cnt, saturating at STARVE_LIMIT. Any IFU grant clears it.
- Grant timing: a grant decided in cycle N causes the following at edge N+1:
  - The state enters the matching X_ACC state.
  - The address (and, for the LSU, wdata and we) are latched into mem_addr_out / mem_wdata_out.
  - mem_read_out, or mem_write_out when lsu_we_in = 1, goes high.
  - The matching gnt_out pulses high for exactly cycle N+1.
  - Requester inputs are ignored until the next IDLE.
- X_ACC:
  - The strobe is held and the timeout counter increments each cycle.
  - mem_valid_in is accepted in any ACC cycle, including the first (zero-wait memory).
  - On a cycle with mem_valid_in: capture mem_rdata_in into the owner's data register (reads only; writes leave it unchanged) and drop the strobe at the next edge. The owner's valid_out pulses for one cycle, then return to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without mem_valid_in: drop the strobe, pulse valid_out and err_out together, force the data register to 32'h0, and return to IDLE.
  - mem_valid_in in the timeout cycle itself counts as success.
- Latency:
  - Minimum 3 cycles from request to valid: request at N, grant/strobe at N+1, valid at N+2 with zero-wait memory.
  - After completion, IDLE lasts at least 1 cycle before the next grant.
- Data registers hold their value until overwritten. Only the valid/gnt/err outputs pulse.
- halt_in rising during IFU_ACC does not abort the in-flight fetch.
- mem_read_out and mem_write_out are never high simultaneously.
- mem_valid_in is ignored outside X_ACC.

Decomposition:
- Shared package core101_pkg:
  - State encoding localparams: ARB_IDLE = 2'd0, ARB_IFU = 2'd1, ARB_LSU = 2'd2.
  - Owner ID constants.
- Natural sub-module: arb_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired at TIMEOUT_CYCLES.
- Arbitration logic stays in the top FSM.

Test Plan:
- IFU-only read with zero-wait memory (addr 0x10, rdata 0xDEADBEEF, valid in first ACC cycle):
  - Grant at N+1.
  - mem_read_out high 1 cycle.
  - ifu_valid_out at N+2 with ifu_data_out = 0xDEADBEEF.
- LSU write (addr 0x40, wdata 0x12345678), memory valid after 3 wait cycles:
  - mem_write_out high 4 cycles, mem_read_out stays 0.
  - lsu_valid_out pulse, lsu_rdata_out unchanged.
- Both requesting continuously, STARVE_LIMIT = 4:
  - Grant order is LSU, LSU, LSU, LSU, IFU, LSU...
  - starve_cnt clears after the IFU grant.
- No mem_valid_in, TIMEOUT_CYCLES = 16:
  - The strobe drops after 16 ACC cycles.
  - lsu_valid_out and lsu_err_out pulse together, lsu_rdata_out = 0.
  - Next request is granted normally.
- halt_in = 1 with only ifu_req_in high:
  - No grant.
  - Deassert halt_in: grant on the next cycle.
  - Halt asserted mid-fetch: the fetch still completes.
- reset_in asserted during LSU_ACC, then late mem_valid_in:
  - All outputs 0, no valid pulse.
  - The late valid is ignored, state = IDLE.
